// File: rtl/dff_ctrl_pkg.sv
// Shared types and helpers for the DFF preset/clear control sequencer.
// The optional conflict counter in dff_ctrl_seq is built only when DFF_CTRL_SEQ_CONF_CNT_EN is defined.
package dff_ctrl_pkg;

  typedef enum logic [1:0] {
    READY   = 2'd0,
    PULSE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  typedef enum logic {
    KIND_CLR = 1'b0,
    KIND_SET = 1'b1
  } kind_t;

  // One bit of headroom so the pulse counter can saturate at PW_CYC itself.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/dff_ctrl_sync.sv
// Multi-stage synchroniser for one active-low asynchronous request pin.
// It resets to all ones, which is the idle (released) level of the request.
module dff_ctrl_sync
  import dff_ctrl_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic preset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock or negedge preset) begin
    if (!preset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dff_ctrl_seq.sv
// Sequencer producing glitch-free, mutually exclusive active-low clear/preset pulses for the DFF cell.
// Define DFF_CTRL_SEQ_CONF_CNT_EN to add the saturating conf_cnt port counting cycles with both requests active.
//
// state   | meaning
// READY   | both controls released and recovered, enable=1
// PULSE   | selected control low, at least PW_CYC cycles and while its request is held
// RECOVER | both controls high, counting REC_CYC cycles before enable rises
module dff_ctrl_seq
  import dff_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PW_CYC      = 3,
  parameter int REC_CYC     = 2
`ifdef DFF_CTRL_SEQ_CONF_CNT_EN
  ,
  parameter int CNT_W       = 8
`endif
) (
  input  logic             clock,
  input  logic             preset,
  input  logic             clr_req_n,
  input  logic             set_req_n,
  output logic             clear_o,
  output logic             preset_o,
  output logic             enable,
  output logic             busy
`ifdef DFF_CTRL_SEQ_CONF_CNT_EN
  ,
  output logic [CNT_W-1:0] conf_cnt
`endif
);

  localparam int CW = cnt_width(PW_CYC, REC_CYC);
  localparam logic [CW-1:0] PW_LAST  = CW'(PW_CYC - 1);
  localparam logic [CW-1:0] PW_MAX   = CW'(PW_CYC);
  localparam logic [CW-1:0] REC_LAST = CW'(REC_CYC - 1);

  logic w_clr_sync_n;
  logic w_set_sync_n;
  logic w_clr_s;
  logic w_set_s;
  logic w_kind_req;

  state_t        r_state;
  kind_t         r_kind;
  logic [CW-1:0] r_cnt;
  logic          r_clear_n;
  logic          r_preset_n;
  logic          r_enable;
  logic          r_busy;

  dff_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_clr (
    .clock  (clock),
    .preset (preset),
    .i_d    (clr_req_n),
    .o_q    (w_clr_sync_n)
  );

  dff_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_set (
    .clock  (clock),
    .preset (preset),
    .i_d    (set_req_n),
    .o_q    (w_set_sync_n)
  );

  assign w_clr_s    = ~w_clr_sync_n;
  assign w_set_s    = ~w_set_sync_n;
  assign w_kind_req = (r_kind == KIND_CLR) ? w_clr_s : w_set_s;

  // Outputs are decoded from the next state in the same edge, so they are pure flops.
  always_ff @(posedge clock or negedge preset) begin
    if (!preset) begin
      r_state    <= PULSE;
      r_kind     <= KIND_CLR;
      r_cnt      <= '0;
      r_clear_n  <= 1'b0;
      r_preset_n <= 1'b1;
      r_enable   <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        READY, RECOVER: begin
          if (w_clr_s || w_set_s) begin
            r_state    <= PULSE;
            r_kind     <= w_clr_s ? KIND_CLR : KIND_SET;
            r_cnt      <= '0;
            r_clear_n  <= ~w_clr_s;
            r_preset_n <= w_clr_s;
            r_enable   <= 1'b0;
            r_busy     <= 1'b1;
          end else if (r_state == RECOVER) begin
            if (r_cnt == REC_LAST) begin
              r_state  <= READY;
              r_cnt    <= '0;
              r_enable <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        PULSE: begin
          // A held request keeps the pulse going; the counter parks at PW_CYC.
          if ((r_cnt >= PW_LAST) && !w_kind_req) begin
            r_state    <= RECOVER;
            r_cnt      <= '0;
            r_clear_n  <= 1'b1;
            r_preset_n <= 1'b1;
          end else if (r_cnt != PW_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= RECOVER;
          r_cnt      <= '0;
          r_clear_n  <= 1'b1;
          r_preset_n <= 1'b1;
          r_enable   <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  assign clear_o  = r_clear_n;
  assign preset_o = r_preset_n;
  assign enable   = r_enable;
  assign busy     = r_busy;

`ifdef DFF_CTRL_SEQ_CONF_CNT_EN
  logic [CNT_W-1:0] r_conf_cnt;

  always_ff @(posedge clock or negedge preset) begin
    if (!preset) begin
      r_conf_cnt <= '0;
    end else if (w_clr_s && w_set_s && (r_conf_cnt != '1)) begin
      r_conf_cnt <= r_conf_cnt + 1'b1;
    end
  end

  assign conf_cnt = r_conf_cnt;
`endif

endmodule

// File: tb/tb_dff_ctrl_seq.sv
// Scoreboard bench for dff_ctrl_seq: stimulus queues expected output changes, a monitor checks them.
// Build with DFF_CTRL_SEQ_CONF_CNT_EN defined to also check conf_cnt.
module tb_dff_ctrl_seq;

  logic clock;
  logic preset;
  logic clr_req_n;
  logic set_req_n;
  logic clear_o;
  logic preset_o;
  logic enable;
  logic busy;
`ifdef DFF_CTRL_SEQ_CONF_CNT_EN
  logic [7:0] conf_cnt;
`endif

  dff_ctrl_seq #(
    .SYNC_STAGES (2),
    .PW_CYC      (3),
    .REC_CYC     (2)
  ) dut (
    .clock     (clock),
    .preset    (preset),
    .clr_req_n (clr_req_n),
    .set_req_n (set_req_n),
    .clear_o   (clear_o),
    .preset_o  (preset_o),
    .enable    (enable),
    .busy      (busy)
`ifdef DFF_CTRL_SEQ_CONF_CNT_EN
    ,
    .conf_cnt  (conf_cnt)
`endif
  );

  // {clear_o, preset_o, enable, busy}
  localparam logic [3:0] V_CLR = 4'b0101;
  localparam logic [3:0] V_SET = 4'b1001;
  localparam logic [3:0] V_REC = 4'b1101;
  localparam logic [3:0] V_RDY = 4'b1110;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   base;
  logic [3:0] prev_vec = 4'bxxxx;
  logic [3:0] vec;

  assign vec = {clear_o, preset_o, enable, busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic push(input int c, input logic [3:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Monitor: every output change must match the next queued expectation, value and cycle.
  always @(negedge clock) begin
    exp_t e;
    n_checks++;
    if ((clear_o === 1'b0 && preset_o === 1'b0) || (busy !== ~enable) ||
        (enable === 1'b1 && !(clear_o === 1'b1 && preset_o === 1'b1))) begin
      n_errors++;
      $display("FAIL invariant: outputs %b at cycle %0d", vec, cyc);
    end
    if (vec !== prev_vec) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_change: got %b at cycle %0d, expected no change", vec, cyc);
      end else begin
        e = sb.pop_front();
        if (e.vec !== vec || e.cyc != cyc) begin
          n_errors++;
          $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                   e.name, vec, cyc, e.vec, e.cyc);
        end
      end
      prev_vec = vec;
    end
  end

  initial begin
    preset    = 1'b0;
    clr_req_n = 1'b1;
    set_req_n = 1'b1;
    push(1, V_CLR, "reset_vec");

    // 1: power-up clear pulse, recovery, ready
    step(3);
    check("reset_outputs", {4'h0, vec}, {4'h0, V_CLR});
`ifdef DFF_CTRL_SEQ_CONF_CNT_EN
    check("reset_conf_cnt", conf_cnt, 8'd0);
`endif
    base = cyc;
    push(base + 3, V_REC, "t1_recover");
    push(base + 5, V_RDY, "t1_ready");
    preset = 1'b1;
    step(8);

    // 2: one-cycle set request
    base = cyc;
    push(base + 3, V_SET, "t2_set_pulse");
    push(base + 6, V_REC, "t2_recover");
    push(base + 8, V_RDY, "t2_ready");
    set_req_n = 1'b0;
    step(1);
    set_req_n = 1'b1;
    step(9);

    // 3: clear held for 10 cycles
    base = cyc;
    push(base + 3,  V_CLR, "t3_clr_pulse");
    push(base + 13, V_REC, "t3_recover");
    push(base + 15, V_RDY, "t3_ready");
    clr_req_n = 1'b0;
    step(10);
    clr_req_n = 1'b1;
    step(8);

    // 4: both requests together for 2 cycles, clear wins
    base = cyc;
    push(base + 3, V_CLR, "t4_clr_wins");
    push(base + 6, V_REC, "t4_recover");
    push(base + 8, V_RDY, "t4_ready");
    clr_req_n = 1'b0;
    set_req_n = 1'b0;
    step(2);
    clr_req_n = 1'b1;
    set_req_n = 1'b1;
    step(8);
`ifdef DFF_CTRL_SEQ_CONF_CNT_EN
    check("conf_cnt_overlap", conf_cnt, 8'd2);
`endif

    // 5: clear request lands during recovery of a set pulse
    base = cyc;
    push(base + 3,  V_SET, "t5_set_pulse");
    push(base + 6,  V_REC, "t5_recover1");
    push(base + 7,  V_CLR, "t5_reenter_pulse");
    push(base + 10, V_REC, "t5_recover2");
    push(base + 12, V_RDY, "t5_ready");
    set_req_n = 1'b0;
    step(1);
    set_req_n = 1'b1;
    step(3);
    clr_req_n = 1'b0;
    step(1);
    clr_req_n = 1'b1;
    step(10);

    // 6: reset asserted in the middle of a set pulse
    base = cyc;
    push(base + 3,  V_SET, "t6_set_pulse");
    push(base + 4,  V_CLR, "t6_async_reset");
    push(base + 8,  V_REC, "t6_recover");
    push(base + 10, V_RDY, "t6_ready");
    set_req_n = 1'b0;
    step(1);
    set_req_n = 1'b1;
    step(3);
    preset = 1'b0;
    #1;
    check("async_reset_outputs", {4'h0, vec}, {4'h0, V_CLR});
`ifdef DFF_CTRL_SEQ_CONF_CNT_EN
    check("async_reset_conf_cnt", conf_cnt, 8'd0);
`endif
    step(1);
    preset = 1'b1;
    step(8);

    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
